// File: rtl/lfsr_17_rx.sv
// lfsr_17_rx: self-synchronous 7-bit-per-beat descrambler with
// a per-frame 64-bit Galois signature and end-of-frame compare.
module lfsr_17_rx #(
  parameter int LANES = 7,
  parameter int HIST  = 58
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_data,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [63:0]      sig_seed,
  input  logic [63:0]      expected_sig,
  output logic             out_valid,
  output logic [LANES-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             locked,
  output logic [63:0]      sig_value,
  output logic             sig_done,
  output logic             sig_match,
  output logic             sof_err
);

  localparam int TAP = 39;
  localparam int CW  = $clog2(HIST + 1);
  localparam logic [63:0] TAPMASK = 64'hC96C_5795_D787_0F42;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [HIST-1:0] r_hist;
  logic [HIST-1:0] w_hist_nx;
  logic [LANES-1:0] w_desc;
  logic [63:0]     r_sig;
  logic [63:0]     w_sig_nx;
  logic [CW-1:0]   r_cnt;
  logic            w_hash;
  logic            w_seed;
  logic            w_done;
  logic            w_serr;

  assign locked = (r_cnt == CW'(HIST));

  // Descramble lane 0 first, rolling each received bit into history.
  always_comb begin
    w_hist_nx = r_hist;
    w_desc    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_desc[i] = in_data[i] ^ w_hist_nx[TAP-1] ^ w_hist_nx[HIST-1];
      w_hist_nx = {w_hist_nx[HIST-2:0], in_data[i]};
    end
  end

  // Fold the descrambled beat into the signature, seeding on SOF.
  always_comb begin
    w_sig_nx = w_seed ? sig_seed : r_sig;
    for (int i = 0; i < LANES; i++) begin
      w_sig_nx = {w_sig_nx[62:0], w_desc[i]}
               ^ (w_sig_nx[63] ? TAPMASK : 64'd0);
    end
  end

  // Frame tracking: decides hashing, seeding, completion and abort.
  always_comb begin
    w_state_nx = r_state;
    w_hash     = 1'b0;
    w_seed     = 1'b0;
    w_done     = 1'b0;
    w_serr     = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (in_sof) begin
            w_seed = 1'b1;
            w_hash = 1'b1;
            w_done = in_eof;
            w_state_nx = in_eof ? S_IDLE : S_FRAME;
          end
        end
        S_FRAME: begin
          w_hash = 1'b1;
          w_seed = in_sof;
          w_serr = in_sof;
          w_done = in_eof;
          if (in_eof) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Datapath: history, lock counter, signature and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist    <= '0;
      r_sig     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      sig_value <= '0;
      sig_done  <= 1'b0;
      sig_match <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_sof   <= in_valid & in_sof;
      out_eof   <= in_valid & in_eof;
      sig_done  <= w_done;
      sof_err   <= w_serr;
      if (in_valid) begin
        out_data <= w_desc;
        r_hist   <= w_hist_nx;
        if (r_cnt < CW'(HIST - LANES)) r_cnt <= r_cnt + CW'(LANES);
        else                           r_cnt <= CW'(HIST);
      end
      if (w_hash) r_sig <= w_sig_nx;
      if (w_done) begin
        sig_value <= w_sig_nx;
        sig_match <= (w_sig_nx == expected_sig);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_17_rx.sv
// tb_lfsr_17_rx: scoreboard bench for lfsr_17_rx with a bit-level
// scrambler, descrambler and signature model.
module tb_lfsr_17_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [6:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [63:0] sig_seed = '0;
  logic [63:0] expected_sig = '0;
  logic        out_valid;
  logic [6:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        locked;
  logic [63:0] sig_value;
  logic        sig_done;
  logic        sig_match;
  logic        sof_err;

  lfsr_17_rx dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
    .sig_seed(sig_seed), .expected_sig(expected_sig),
    .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof),
    .locked(locked), .sig_value(sig_value),
    .sig_done(sig_done), .sig_match(sig_match),
    .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  data;
    logic [6:0]  pl;
    logic        chk_pl;
    logic        sof;
    logic        eof;
    logic        locked;
    logic        serr;
    logic        done;
    logic        match;
    logic [63:0] val;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          n_serr = 0;
  logic [63:0] tapmask;
  logic [57:0] m_h;
  logic [57:0] sc_h;
  logic [63:0] m_r;
  logic [63:0] m_val;
  logic        m_match;
  logic        m_frame;
  int          m_cnt;
  logic [6:0]  last_data = '0;
  logic [63:0] g_seed = '0;
  logic [63:0] g_xs = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sig_step(input logic [63:0] r,
                                           input logic d);
    return {r[62:0], d} ^ (r[63] ? tapmask : 64'd0);
  endfunction

  // Monitor: pop the scoreboard on every output beat.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (sig_done) n_done++;
      if (sof_err) n_serr++;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("data", out_data, e.data);
          chk("sof", out_sof, e.sof);
          chk("eof", out_eof, e.eof);
          chk("locked", locked, e.locked);
          chk("sof_err", sof_err, e.serr);
          chk("sig_done", sig_done, e.done);
          chk("sig_match", sig_match, e.match);
          chk("sig_value", sig_value, e.val);
          if (e.chk_pl) chk("payload", out_data, e.pl);
        end
        last_data = out_data;
      end else begin
        chk("idle_done", sig_done, 0);
        chk("idle_serr", sof_err, 0);
        chk("hold_data", out_data, last_data);
      end
    end
  end

  task automatic chk_zero();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_eof", out_eof, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sigval", sig_value, 0);
    chk("rst_done", sig_done, 0);
    chk("rst_match", sig_match, 0);
    chk("rst_serr", sof_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = '0;
    q.delete();
    m_h = '0; m_r = '0; m_val = '0; m_match = 1'b0;
    m_frame = 1'b0; m_cnt = 0; last_data = '0;
    #1;
    chk_zero();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Drive one cycle; on valid beats run the model and push the result.
  task automatic send(input logic v, input logic [6:0] pl,
                      input logic sof, input logic eof,
                      input logic scr, input logic want_match,
                      input logic chk_pl, input logic [6:0] xp);
    exp_t e;
    logic [6:0] dat;
    logic s;
    logic hash;
    @(posedge clk); #1;
    dat = pl;
    if (v && scr) begin
      for (int i = 0; i < 7; i++) begin
        s = pl[i] ^ sc_h[38] ^ sc_h[57];
        sc_h = {sc_h[56:0], s};
        dat[i] = s;
      end
    end
    in_valid = v;
    in_data = v ? dat : 7'd0;
    in_sof = v & sof;
    in_eof = v & eof;
    sig_seed = g_seed;
    expected_sig = g_xs;
    if (v) begin
      e.data = '0;
      for (int i = 0; i < 7; i++) begin
        e.data[i] = dat[i] ^ m_h[38] ^ m_h[57];
        m_h = {m_h[56:0], dat[i]};
      end
      m_cnt = (m_cnt + 7 > 58) ? 58 : m_cnt + 7;
      hash = m_frame;
      e.serr = sof & m_frame;
      e.done = 1'b0;
      if (sof) begin
        m_r = g_seed;
        hash = 1'b1;
      end
      if (hash) begin
        for (int i = 0; i < 7; i++) m_r = sig_step(m_r, e.data[i]);
      end
      if (hash && eof) begin
        if (want_match) expected_sig = m_r;
        m_val = m_r;
        m_match = (m_r == expected_sig);
        m_frame = 1'b0;
        e.done = 1'b1;
      end else if (sof) begin
        m_frame = 1'b1;
      end
      e.sof = sof;
      e.eof = eof;
      e.locked = (m_cnt == 58);
      e.match = m_match;
      e.val = m_val;
      e.pl = scr ? pl : xp;
      e.chk_pl = chk_pl;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
  endtask

  initial begin
    int taps[$] = {1, 6, 8, 9, 10, 11, 16, 17, 18, 23, 24, 25, 26,
                   28, 30, 31, 32, 34, 36, 39, 40, 41, 42, 44, 46,
                   50, 51, 53, 54, 56, 59, 62, 63};
    logic open;
    logic sof;
    logic eof;
    logic [6:0] xp;
    tapmask = '0;
    foreach (taps[k]) tapmask[taps[k]] = 1'b1;
    sc_h = '0;

    // zeros with no frame: out_data 0, lock with the 9th beat
    do_reset();
    for (int b = 0; b < 12; b++)
      send(1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
    idle(3);

    // impulse: d = 1 at bit offsets 0, 39 and 58 only
    do_reset();
    for (int b = 0; b < 12; b++) begin
      xp = (b == 0) ? 7'h01 : (b == 5) ? 7'h10 : (b == 8) ? 7'h04 : 7'h00;
      send(1'b1, (b == 0) ? 7'd1 : 7'd0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, xp);
    end
    idle(3);

    // single-beat frames, matching and non-matching reference
    do_reset();
    n_done = 0;
    g_seed = 64'h8000_0000_0000_0000;
    send(1'b1, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'd0);
    idle(2);
    chk("single_done_cnt", n_done, 1);
    chk("single_match", sig_match, 1);
    g_seed = 64'h0123_4567_89AB_CDEF;
    g_xs = 64'h5555_0000_AAAA_1111;
    send(1'b1, 7'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    idle(2);
    chk("single2_done_cnt", n_done, 2);

    // SOF at 3, SOF again at 5, EOF at 8
    n_done = 0;
    n_serr = 0;
    for (int b = 0; b < 10; b++) begin
      g_seed = {$urandom, $urandom};
      send(1'b1, 7'($urandom), b == 3 || b == 5, b == 8, 1'b0,
           1'b1, 1'b0, 7'd0);
    end
    idle(2);
    chk("abort_serr_cnt", n_serr, 1);
    chk("abort_done_cnt", n_done, 1);
    chk("abort_match", sig_match, 1);

    // reset on beat 4 of a 10-beat frame
    n_done = 0;
    do_reset();
    for (int b = 0; b < 4; b++)
      send(1'b1, 7'($urandom), b == 0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    do_reset();
    for (int b = 5; b < 14; b++)
      send(1'b1, 7'($urandom), 1'b0, b == 9, 1'b0, 1'b1, 1'b0, 7'd0);
    idle(2);
    chk("rst_frame_done_cnt", n_done, 0);
    chk("relock", locked, 1);

    // random scrambled stream with random framing
    do_reset();
    sc_h = {$urandom, $urandom};
    open = 1'b0;
    n_done = 0;
    for (int b = 0; b < 1000; b++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      sof = open ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 5) == 0);
      eof = (open || sof) && ($urandom_range(0, 9) == 0);
      g_seed = {$urandom, $urandom};
      g_xs = {$urandom, $urandom};
      send(1'b1, 7'($urandom), sof, eof, 1'b1,
           1'($urandom_range(0, 1)), b >= 9, 7'd0);
      open = (open || sof) && !eof;
    end
    idle(3);
    chk("sb_drain", q.size(), 0);
    if (n_done == 0) chk("rand_frames_seen", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_17_rx.md
# lfsr_17_rx

Receive-side counterpart of the 7-bit-per-cycle scrambler path. It self-synchronously descrambles a 7-bit-per-beat scrambled stream and passes the recovered bits downstream. Each framed payload is also folded into a 64-bit Galois signature LFSR that uses the same tap set as the transmit-side 64-bit register. At end of frame it compares the signature against an expected value. The block sits between the lane deserializer and the frame checker.

## Interface
- LANES, 7, bits per beat; bit 0 is the oldest in time.
- HIST, 58, descrambler history depth; taps at delays 39 and 58.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat strobe; no backpressure.
- in_data  in  LANES  scrambled bits.
- in_sof  in  1  first beat of frame; qualified by in_valid.
- in_eof  in  1  last beat of frame; qualified by in_valid.
- sig_seed  in  64  signature seed, sampled on the SOF beat.
- expected_sig  in  64  reference signature, sampled on the EOF beat.
- out_valid  out  1  registered copy of in_valid.
- out_data  out  LANES  descrambled bits.
- out_sof, out_eof  out  1  registered copies of in_sof and in_eof.
- locked  out  1  history fully primed.
- sig_value  out  64  final signature; holds until the next EOF.
- sig_done  out  1  one-cycle pulse after the EOF beat.
- sig_match  out  1  sig_value == expected_sig; valid with sig_done, then held.
- sof_err  out  1  one-cycle pulse when SOF arrives inside an open frame.

## Operation
- History h[0..57]: h[0] is the most recent previous received bit.
- Per lane, processed in order lane 0 to lane 6 within a beat:
  - d = s ^ h[38] ^ h[57].
  - Then shift s into h[0].
- History updates only on in_valid beats, whether or not a frame is open.
- Bit counter saturates at 58 and counts accepted bits since reset. locked = 1 once the counter reaches 58, i.e. after the 9th valid beat.
- out_data is produced regardless of lock state.
- Signature register r[63:0], updated per descrambled bit d when hashing is active:
  - msb = r[63].
  - r' = {r[62:0], d} ^ (msb ? TAPMASK : 0).
  - TAPMASK bits: 1,6,8,9,10,11,16,17,18,23,24,25,26,28,30,31,32,34,36,39,40,41,42,44,46,50,51,53,54,56,59,62,63. Bit 0 receives d only.
- FSM states: IDLE and FRAME.
  - IDLE: beats without SOF are descrambled and passed through but not hashed.
  - IDLE, SOF beat: r := sig_seed, then the beat's 7 bits are hashed. Go to FRAME unless EOF is on the same beat.
  - FRAME: every valid beat is hashed.
  - FRAME, EOF beat: hash the beat, then latch sig_value, sig_match and sig_done. Return to IDLE.
  - SOF and EOF on the same beat: single-beat frame. Seed, hash 7 bits, complete.
  - SOF while in FRAME: pulse sof_err, discard the partial signature, reseed from sig_seed and stay in FRAME. No sig_done is produced for the aborted frame.
  - EOF while in IDLE without SOF: ignored. No sig_done.
- Reset mid-frame: all state is cleared immediately. The frame is lost with no sig_done. locked drops and re-priming is required.

## Timing
- Latency: 1 cycle. Outputs for the beat at edge N appear after edge N, and out_* align with that beat.
- sig_done and sig_match are asserted in the same cycle as out_eof for that beat.
- Reset values, all outputs 0: out_valid, out_data, out_sof, out_eof, locked, sig_value, sig_done, sig_match, sof_err.
- Internal state after reset: h = 0, r = 0, bit counter 0, FSM in IDLE.
- in_valid = 0: no state change. out_valid = 0 and out_data holds its last value.

## Test plan
- Reset, then 12 beats of in_data = 0 with no frame -> out_data = 0 on every beat; locked rises together with the out_valid of the 9th beat.
- Impulse: beat 0 = 7'b0000001, then zeros -> d = 1 at bit offsets 0, 39 and 58. These are out_data[0] of beat 0, out_data[4] of beat 5 and out_data[2] of beat 8; all other bits are 0.
- Single-beat frame (SOF and EOF together), sig_seed = 64'h8000_0000_0000_0000, history zero, in_data = 0. Expected sig_value: bit 1 shifts the seed's msb out, giving TAPMASK; the remaining 6 shifts follow the register rule. The bench compares against the software model; sig_done is one pulse and sig_match = 1 when expected_sig equals the model value.
- SOF at beat 3, second SOF at beat 5, EOF at beat 8 -> sof_err pulses once, aligned with beat 5; the signature equals the model seeded at beat 5 only; exactly one sig_done.
- Reset asserted on beat 4 of a 10-beat frame -> all outputs 0 immediately; no sig_done; locked = 0 until 9 further valid beats.
- Random 1000-beat stream produced by the software scrambler model -> out_data equals the original payload from beat 9 on; framed signatures match the model.
